// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequential ALU controller, one operation in flight at a time.
//
// A request (in_a, in_b, in_func) is accepted on a valid/ready handshake and latched.
// The controller runs it over one or more cycles. The 2*width-bit result and the
// error flag are then held on a valid/ready result port until they are consumed.
//   func 00 add, 01 sub, 10 mul (signed operands, full-width result)
//   func 11 div (unsigned, result {quotient, remainder}, out_err on divide-by-zero)
// Latency from the accepting edge to out_valid: add/sub 1 edge, mul/div width+1 edges.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     request handshake; in_ready is high only in IDLE
//   in_a, in_b, in_func   operands and op code
//   out_valid/out_ready   result handshake; out_valid is high only in DONE
//   out_result, out_err   result and divide-by-zero flag, held while out_valid
//   busy                  high while an operation is executing or waiting to be consumed
module alu_seq_ctrl #(
  parameter int unsigned width = 6,
  parameter int unsigned cnt_w = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [width-1:0]     in_a,
  input  logic [width-1:0]     in_b,
  input  logic [1:0]           in_func,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*width-1:0]   out_result,
  output logic                 out_err,
  output logic                 busy
);

  localparam logic [1:0] FuncAdd = 2'b00;
  localparam logic [1:0] FuncSub = 2'b01;
  localparam logic [1:0] FuncMul = 2'b10;
  localparam logic [1:0] FuncDiv = 2'b11;

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e               state_q, state_d;
  logic [1:0]           func_q, func_d;
  // a_q: operand a (add/sub), dividend shifting into quotient (div); unused for mul.
  // b_q: operand b (add/sub/div), |b| shifting right (mul).
  logic [width-1:0]     a_q, a_d;
  logic [width-1:0]     b_q, b_d;
  logic                 sign_q, sign_d;
  logic [cnt_w-1:0]     cnt_q, cnt_d;
  // fin_q marks that all iterations are done; the next edge finalises the result.
  logic                 fin_q, fin_d;
  // acc_q: product accumulator (mul) or partial remainder in the low half (div).
  logic [2*width-1:0]   acc_q, acc_d;
  logic [2*width-1:0]   mcand_q, mcand_d;
  logic [2*width-1:0]   res_q, res_d;
  logic                 err_q, err_d;

  // Operand magnitudes; -(2**(width-1)) maps to 2**(width-1), which still fits
  // as an unsigned width-bit value.
  logic [width-1:0]     a_mag, b_mag;
  // Restoring-division step.
  logic [width:0]       rem_shift;
  logic [width-1:0]     rem_diff;
  logic                 rem_ge;

  always_comb begin
    a_mag     = in_a[width-1] ? -in_a : in_a;
    b_mag     = in_b[width-1] ? -in_b : in_b;
    rem_shift = {acc_q[width-1:0], a_q[width-1]};
    rem_ge    = rem_shift >= {1'b0, b_q};
    rem_diff  = rem_shift[width-1:0] - b_q;
  end

  always_comb begin
    state_d = state_q;
    func_d  = func_q;
    a_d     = a_q;
    b_d     = b_q;
    sign_d  = sign_q;
    cnt_d   = cnt_q;
    fin_d   = fin_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    res_d   = res_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          func_d  = in_func;
          cnt_d   = '0;
          fin_d   = 1'b0;
          acc_d   = '0;
          sign_d  = in_a[width-1] ^ in_b[width-1];
          state_d = StExec;
          if (in_func == FuncMul) begin
            a_d     = a_mag;
            b_d     = b_mag;
            mcand_d = {{width{1'b0}}, a_mag};
          end else begin
            a_d     = in_a;
            b_d     = in_b;
            mcand_d = '0;
          end
        end
      end

      StExec: begin
        unique case (func_q)
          FuncAdd: begin
            res_d   = {{width{a_q[width-1]}}, a_q} + {{width{b_q[width-1]}}, b_q};
            err_d   = 1'b0;
            state_d = StDone;
          end
          FuncSub: begin
            res_d   = {{width{a_q[width-1]}}, a_q} - {{width{b_q[width-1]}}, b_q};
            err_d   = 1'b0;
            state_d = StDone;
          end
          FuncMul: begin
            if (fin_q) begin
              res_d   = sign_q ? -acc_q : acc_q;
              err_d   = 1'b0;
              state_d = StDone;
            end else begin
              if (b_q[0]) begin
                acc_d = acc_q + mcand_q;
              end
              mcand_d = mcand_q << 1;
              b_d     = b_q >> 1;
            end
          end
          FuncDiv: begin
            if (fin_q) begin
              // b == 0 falls out naturally as q = all ones, r = a.
              res_d   = {a_q, acc_q[width-1:0]};
              err_d   = (b_q == '0);
              state_d = StDone;
            end else begin
              acc_d = {{width{1'b0}}, rem_ge ? rem_diff : rem_shift[width-1:0]};
              a_d   = {a_q[width-2:0], rem_ge};
            end
          end
          default: state_d = StIdle;
        endcase

        // Iteration counter for mul/div: stops at width-1, never wraps.
        if ((func_q == FuncMul || func_q == FuncDiv) && !fin_q) begin
          if (cnt_q == cnt_w'(width - 1)) begin
            fin_d = 1'b1;
          end else begin
            cnt_d = cnt_q + cnt_w'(1);
          end
        end
      end

      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      func_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      cnt_q   <= '0;
      fin_q   <= 1'b0;
      acc_q   <= '0;
      mcand_q <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      func_q  <= func_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      cnt_q   <= cnt_d;
      fin_q   <= fin_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StDone);
  assign busy       = (state_q != StIdle);
  assign out_result = res_q;
  assign out_err    = err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: requests are driven in sequence, expected
// results (from a small behavioural model) go into a scoreboard queue and are
// popped and compared when the DUT raises out_valid.
module tb_alu_seq_ctrl;

  localparam int W = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_a = '0;
  logic [W-1:0]     in_b = '0;
  logic [1:0]       in_func = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [2*W-1:0]   out_result;
  logic             out_err;
  logic             busy;

  alu_seq_ctrl #(.width(W), .cnt_w(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_func    (in_func),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_err    (out_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] res;
    logic           err;
    int             lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [1:0] f);
    exp_t e;
    int   sa;
    int   sb;
    sa    = $signed(a);
    sb    = $signed(b);
    e.err = 1'b0;
    e.lat = 1;
    case (f)
      2'b00: e.res = (2*W)'(sa + sb);
      2'b01: e.res = (2*W)'(sa - sb);
      2'b10: begin
        e.res = (2*W)'(sa * sb);
        e.lat = W + 1;
      end
      default: begin
        e.lat = W + 1;
        if (b == '0) begin
          e.res = {{W{1'b1}}, a};
          e.err = 1'b1;
        end else begin
          e.res = {W'(a / b), W'(a % b)};
        end
      end
    endcase
    return e;
  endfunction

  // Present a request at a negedge; returns #1 after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] f,
                      input bit push);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_a     = a;
    in_b     = b;
    in_func  = f;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = W'($urandom);
    in_b     = W'($urandom);
    in_func  = 2'($urandom);
    if (push) exp_q.push_back(model(a, b, f));
  endtask

  // Count edges until out_valid (bounded), then compare against the scoreboard.
  task automatic wait_result(input string tag);
    exp_t e;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fails++;
      $error("FAIL %s_scoreboard: observed empty queue expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_result"}, out_result, e.res);
      check({tag, "_err"}, out_err, e.err);
      check({tag, "_latency"}, lat, e.lat);
      check({tag, "_busy"}, busy, 1);
      check({tag, "_in_ready_done"}, in_ready, 0);
    end
  endtask

  task automatic consume(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_valid_after"}, out_valid, 0);
    check({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2*W-1:0] held;
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;
    logic [1:0]     rf;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_result", out_result, 0);
    check("rst_out_err", out_err, 0);
    rst_n = 1'b1;

    // Idle with in_valid low and inputs wiggling: nothing starts
    repeat (3) begin
      @(negedge clk);
      in_a = W'($urandom);
      in_b = W'($urandom);
    end
    @(negedge clk);
    check("idle_no_start", busy, 0);

    send(6'd31, 6'd1, 2'b00, 1'b1);
    wait_result("add_31_1");
    consume("add_31_1");

    send(6'h20, 6'd1, 2'b01, 1'b1);
    wait_result("sub_m32_1");
    consume("sub_m32_1");

    send(6'h20, 6'h20, 2'b10, 1'b1);
    wait_result("mul_m32_m32");
    consume("mul_m32_m32");

    send(6'h3D, 6'd5, 2'b10, 1'b1);
    wait_result("mul_m3_5");
    consume("mul_m3_5");

    send(6'd63, 6'd5, 2'b11, 1'b1);
    wait_result("div_63_5");
    consume("div_63_5");

    // Divide by zero, then hold the result for 5 cycles with in_* toggling
    send(6'd45, 6'd0, 2'b11, 1'b1);
    wait_result("div_45_0");
    held = out_result;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom);
      in_a     = W'($urandom);
      in_b     = W'($urandom);
      in_func  = 2'($urandom);
      @(posedge clk);
      #1;
      check("hold_result", out_result, {20'd0, held});
      check("hold_in_ready", in_ready, 0);
      check("hold_valid", out_valid, 1);
    end
    // Request presented on the consuming edge: must wait one cycle
    @(negedge clk);
    in_a      = 6'd10;
    in_b      = 6'h39;
    in_func   = 2'b00;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bubble_valid_low", out_valid, 0);
    check("bubble_not_accepted", busy, 0);
    check("bubble_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bubble_accept_next", busy, 1);
    exp_q.push_back(model(6'd10, 6'h39, 2'b00));
    wait_result("add_after_bubble");
    consume("add_after_bubble");

    // out_ready held high: result consumed on the first DONE cycle
    out_ready = 1'b1;
    send(6'h1F, 6'h20, 2'b10, 1'b1);
    wait_result("mul_ready_high");
    @(posedge clk);
    #1;
    check("ready_high_one_cycle", out_valid, 0);
    out_ready = 1'b0;

    // A few random operations through the scoreboard
    for (int i = 0; i < 6; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rf = 2'(i);
      send(ra, rb, rf, 1'b1);
      wait_result("random_op");
      consume("random_op");
    end

    // Reset in the middle of a multiply abandons it
    send(6'h3B, 6'd7, 2'b10, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_out_result", out_result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(6'd2, 6'd3, 2'b00, 1'b1);
    wait_result("add_after_reset");
    consume("add_after_reset");

    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Sequential controller that executes one ALU operation at a time. Operations arrive on a valid/ready request port, are latched, and are executed over one or more cycles; the 2*width-bit result and error flag are then held on a valid/ready result port. Add and sub complete in one cycle. Signed multiply and unsigned divide use iterative shift-add and restoring-division datapaths owned by this block. The block sits between the switch/key input logic and the bin2bcd/bcd2seg display path, replacing the purely combinational ALU.

Parameters:
width, 6, operand width in bits; result width is 2*width
cnt_w, 3, iteration counter width; must satisfy 2**cnt_w > width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid & in_ready at a rising edge
in_a  in  width  operand a
in_b  in  width  operand b
in_func  in  2  op code: 00 add, 01 sub, 10 mul (all three signed), 11 div (unsigned)
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid & out_ready at a rising edge
out_result  out  2*width  result; for div, {quotient, remainder}
out_err  out  1  divide-by-zero flag, qualified by out_valid
busy  out  1  high in EXEC or DONE

Behaviour:
- Reset, asynchronous: state=IDLE; out_valid=0; out_result=0; out_err=0; busy=0; counter and internal registers cleared. A reset during EXEC or DONE abandons the operation and produces no result.
- FSM states:
  - IDLE: in_ready=1. On accept, latch a, b and func into registers, clear the counter, go to EXEC. Later changes on the in_* inputs have no effect.
  - EXEC: in_ready=0. Behaviour depends on op:
    - add/sub: at the 1st edge, out_result = sign-extend(a) ± sign-extend(b) at 2*width bits, then go to DONE. Latency L=1 edge after the accepting edge.
    - mul: setup latches |a|, |b| and sign = a[msb]^b[msb]. Then width shift-add iterations, one per edge, LSB-first on |b|. The next edge negates the product if sign=1 and goes to DONE. L=width+1. The most negative operand magnitude (2**(width-1)) must be handled without overflow.
    - div: restoring division, MSB-first, one quotient bit per edge, width iterations. The next edge packs {q,r} and goes to DONE. L=width+1. If b==0: result q=all ones, r=a, out_err=1, same latency L.
  - DONE: out_valid=1, busy=1. out_result and out_err are held stable until the edge where out_ready=1; on that edge go to IDLE and clear out_valid.
- No overflow can occur for add/sub/mul, because the full-width result always fits; out_err=0 for these ops.
- Boundary cases:
  - in_ready is low in DONE. A new request on the same cycle as result consumption is not accepted, giving a one-cycle bubble. Back-to-back throughput is therefore L+2 cycles per op.
  - in_valid deasserted while in IDLE: no effect.
  - out_ready held high continuously: the result is consumed on the first DONE cycle.
  - Counter terminal value is width-1, and there is no wrap-around.

Test Plan:
- Reset, then add a=31, b=1 -> out_valid 1 edge after accept; out_result=12'h020; err=0.
- sub a=-32 (6'h20), b=1 -> out_result=12'hFDF; err=0; latency 1.
- mul a=-32, b=-32 -> out_valid exactly 7 edges after accept; out_result=12'h400. Then mul a=-3, b=5 -> 12'hFF1.
- div a=63, b=5 -> out_result=12'h303 (q=12, r=3), err=0, latency 7. Then div a=45, b=0 -> 12'hFED, err=1.
- Hold out_ready=0 for 5 cycles in DONE while toggling in_* inputs -> out_result stable, in_ready=0. Then assert out_ready -> IDLE next edge, and the following request is accepted one cycle later.
- Assert rst_n=0 at iteration 3 of a mul -> out_valid=0 and busy=0 immediately. After release, a fresh add 2+3 -> 12'h005.
